// File: rtl/instr_enc_if.sv
// Command and word streams of the instruction encoder.
// The master side issues field-level commands and accepts encoded words.
// The slave side (the encoder) accepts commands and produces the words.
interface instr_enc_if #(
    parameter int ADDR_W = 32
);
    // Command stream: one field-level instruction description per beat
    logic              s_valid;
    logic              s_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;

    // Word stream: packed instruction words bound for instruction memory
    logic              m_valid;
    logic              m_ready;
    logic [ADDR_W-1:0] m_addr;
    logic [31:0]       m_data;

    modport master (
        output s_valid, fmt, opcode, func3, func7, rd, rs1, rs2, imm, m_ready,
        input  s_ready, m_valid, m_addr, m_data
    );

    modport slave (
        input  s_valid, fmt, opcode, func3, func7, rd, rs1, rs2, imm, m_ready,
        output s_ready, m_valid, m_addr, m_data
    );
endinterface

// File: rtl/instr_enc.sv
// Instruction encoder and program loader.
// Packs R/I/S/B/U field descriptions into RV32 words laid out exactly as the
// core's decoder expects, and streams them out with sequential byte addresses
// so a test loader or the boot/debug path can fill instruction memory.
// Illegal commands are consumed, flagged on err, counted, and produce no word.
module instr_enc #(
    parameter int                ADDR_W = 32,
    parameter int                DEPTH  = 256,
    parameter logic [ADDR_W-1:0] BASE   = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          start_addr,
    instr_enc_if.slave                 bus,
    output logic                       err,
    output logic [7:0]                 err_cnt,
    output logic [$clog2(DEPTH+1)-1:0] words,
    output logic                       busy
);
    localparam int WORDS_W = $clog2(DEPTH + 1);

    // Index of the last word a session may hold; reaching it ends the session
    localparam logic [WORDS_W-1:0] LAST_WORD = WORDS_W'(DEPTH - 1);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FULL
    } state_e;

    state_e            state;
    logic [ADDR_W-1:0] addr_cnt;
    logic              m_valid_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [31:0]       m_data_q;

    logic              accept;
    logic              legal;
    logic [31:0]       enc_word;
    logic              word_taken;
    logic [ADDR_W-1:0] start_base;

    // Word-aligned session base: the low two address bits are always dropped
    assign start_base = start_addr & ~ADDR_W'(3);

    // Combinational ready lets a new command land in the cycle the held word drains
    assign bus.s_ready = (state == ST_RUN) && !start && (!m_valid_q || bus.m_ready);
    assign accept      = bus.s_valid && bus.s_ready;
    assign word_taken  = m_valid_q && bus.m_ready;

    assign bus.m_valid = m_valid_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_data  = m_data_q;
    assign busy        = (state == ST_RUN);

    // Pack the command fields and judge whether the immediate fits its format
    always_comb begin
        logic signed [31:0] imm_s;
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        enc_word = '0;
        legal    = 1'b1;
        imm_s    = $signed(bus.imm);
        case (bus.fmt)
            FMT_R: begin
                enc_word = {bus.func7, bus.rs2, bus.rs1, bus.func3, bus.rd, bus.opcode};
            end
            FMT_I: begin
                enc_word = {bus.imm[11:0], bus.rs1, bus.func3, bus.rd, bus.opcode};
                legal    = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            FMT_S: begin
                enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.func3,
                            bus.imm[4:0], bus.opcode};
                legal    = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
            end
            FMT_B: begin
                enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.func3,
                            bus.imm[4:1], bus.imm[11], bus.opcode};
                // Branch targets are halfword aligned, so bit 0 must be clear
                legal    = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !bus.imm[0];
            end
            FMT_U: begin
                enc_word = {bus.imm[19:0], bus.rd, bus.opcode};
                legal    = (bus.imm[31:20] == 12'h000);
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

    // Session FSM: address counter, word count and the IDLE/RUN/FULL state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the values from before this clock edge.
            state    <= ST_IDLE;
            addr_cnt <= BASE;
            words    <= '0;
        end else if (start) begin
            state    <= ST_RUN;
            addr_cnt <= start_base;
            words    <= '0;
        end else if (accept && legal) begin
            addr_cnt <= addr_cnt + ADDR_W'(4);
            words    <= words + 1'b1;
            if (words == LAST_WORD) begin
                state <= ST_FULL;
            end
        end
    end

    // Output word register: loads on a legal accept, holds under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_addr_q  <= '0;
            m_data_q  <= '0;
        end else if (accept && legal) begin
            m_valid_q <= 1'b1;
            m_addr_q  <= addr_cnt;
            m_data_q  <= enc_word;
        end else if (word_taken) begin
            m_valid_q <= 1'b0;
        end
    end

    // Rejected commands: one-cycle err pulse and a saturating count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= accept && !legal;
            if (accept && !legal && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_instr_enc.sv
// Directed bench for instr_enc with a four-word session depth, so the FULL
// limit is reachable with short hand-written programs.
module tb_instr_enc;
    localparam int ADDR_W  = 32;
    localparam int DEPTH   = 4;
    localparam int WORDS_W = $clog2(DEPTH + 1);

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [ADDR_W-1:0]  start_addr;
    logic               err;
    logic [7:0]         err_cnt;
    logic [WORDS_W-1:0] words;
    logic               busy;

    int n_checks;
    int n_errors;

    instr_enc_if #(.ADDR_W(ADDR_W)) bus ();

    instr_enc #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .BASE   ('0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .bus        (bus),
        .err        (err),
        .err_cnt    (err_cnt),
        .words      (words),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                           input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [31:0] im);
        bus.fmt    = f;
        bus.opcode = op;
        bus.func3  = f3;
        bus.func7  = f7;
        bus.rd     = d;
        bus.rs1    = s1;
        bus.rs2    = s2;
        bus.imm    = im;
    endtask

    // Called at a falling edge; returns at the falling edge after the accept
    task automatic send_cmd(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [31:0] im);
        int n;
        set_cmd(f, op, f3, f7, d, s1, s2, im);
        bus.s_valid = 1'b1;
        n = 0;
        #1;
        while (!bus.s_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.s_ready) begin
            check("accept_timeout", 64'd0, 64'd1);
            bus.s_valid = 1'b0;
            @(negedge clk);
        end else begin
            @(posedge clk);
            @(negedge clk);
            bus.s_valid = 1'b0;
        end
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] a);
        start      = 1'b1;
        start_addr = a;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_words", words, 0);
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        start_addr  = '0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        set_cmd(3'd0, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'h0);

        #3;
        check("rst_s_ready", bus.s_ready, 0);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_addr", bus.m_addr, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_err", err, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_words", words, 0);
        check("rst_busy", busy, 0);

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_s_ready", bus.s_ready, 0);

        // R-format ADD x3,x1,x2; low address bits of start_addr are dropped
        do_start(32'h0000_0102);
        send_cmd(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0);
        check("r_m_valid", bus.m_valid, 1);
        check("r_m_data", bus.m_data, 32'h0020_81B3);
        check("r_m_addr", bus.m_addr, 32'h100);
        check("r_words", words, 1);
        @(negedge clk);
        check("r_drained", bus.m_valid, 0);

        // ADDI then SW back to back, then BEQ and LUI filling the session
        do_start(32'h0000_0100);
        send_cmd(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
        check("i_m_data", bus.m_data, 32'h0050_0093);
        check("i_m_addr", bus.m_addr, 32'h100);
        check("i_s_ready_held", bus.s_ready, 1);
        send_cmd(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8);
        check("s_m_data", bus.m_data, 32'h0020_A423);
        check("s_m_addr", bus.m_addr, 32'h104);
        check("s_words", words, 2);
        send_cmd(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, -32'sd4);
        check("b_m_data", bus.m_data, 32'hFE20_8EE3);
        check("b_m_addr", bus.m_addr, 32'h108);
        send_cmd(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h0001_2345);
        check("u_m_data", bus.m_data, 32'h1234_52B7);
        check("u_m_addr", bus.m_addr, 32'h10C);
        check("full_words", words, 4);
        check("full_busy", busy, 0);

        // Fifth command is refused while the session is FULL
        set_cmd(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1);
        bus.s_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("full_s_ready", bus.s_ready, 0);
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        check("full_no_word", bus.m_valid, 0);
        check("full_words_hold", words, 4);

        // Backpressure: word held stable for five cycles, then drain and reload together
        do_start(32'h0000_0200);
        bus.m_ready = 1'b0;
        send_cmd(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
        set_cmd(3'd1, 7'h13, 3'd0, 7'h00, 5'd2, 5'd0, 5'd0, 32'd7);
        bus.s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_s_ready", bus.s_ready, 0);
            check("bp_m_data", bus.m_data, 32'h0050_0093);
            check("bp_m_addr", bus.m_addr, 32'h200);
            @(negedge clk);
        end
        bus.m_ready = 1'b1;
        #1;
        check("bp_release_ready", bus.s_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
        check("bp_next_valid", bus.m_valid, 1);
        check("bp_next_data", bus.m_data, 32'h0070_0113);
        check("bp_next_addr", bus.m_addr, 32'h204);

        // Out-of-range I immediate: rejected, address not consumed
        send_cmd(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048);
        check("ei_err", err, 1);
        check("ei_err_cnt", err_cnt, 1);
        check("ei_no_word", bus.m_valid, 0);
        check("ei_words", words, 2);
        @(negedge clk);
        check("ei_err_pulse", err, 0);
        send_cmd(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, -32'sd2048);
        check("imin_m_data", bus.m_data, 32'h8000_0093);
        check("imin_m_addr", bus.m_addr, 32'h208);

        // Odd branch offset is rejected; largest legal offset is accepted
        send_cmd(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3);
        check("eb_err_cnt", err_cnt, 2);
        check("eb_words", words, 3);
        send_cmd(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4094);
        check("bmax_m_data", bus.m_data, 32'h7E00_0FE3);
        check("bmax_m_addr", bus.m_addr, 32'h20C);

        // U immediate above 20 bits, illegal format, then saturation
        do_start(32'h0000_0000);
        send_cmd(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h0010_0000);
        check("eu_err_cnt", err_cnt, 3);
        send_cmd(3'd5, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0);
        check("efmt_err_cnt", err_cnt, 4);
        set_cmd(3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0);
        bus.s_valid = 1'b1;
        repeat (300) @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
        check("sat_err_cnt", err_cnt, 255);
        check("sat_words", words, 0);
        check("sat_no_word", bus.m_valid, 0);

        // Reset with a pending word discards it at once
        do_start(32'h0000_0300);
        bus.m_ready = 1'b0;
        send_cmd(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0);
        check("pend_m_valid", bus.m_valid, 1);
        rst_n = 1'b0;
        #1;
        check("arst_m_valid", bus.m_valid, 0);
        check("arst_m_data", bus.m_data, 0);
        check("arst_err_cnt", err_cnt, 0);
        check("arst_words", words, 0);
        check("arst_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
